rr_arb4: RTL and testbench

//  4-requester round-robin arbiter with a bounded grant hold time.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 34 +++
 rtl/rr_arb4.sv | 132 +++++++++++++
 tb/tb_rr_arb4.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin arbiter family.
package arb_pkg;

    localparam int RR_N        = 4;
    localparam int RR_MAX_HOLD = 8;
    localparam int RR_CNT_W    = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
// Scans ptr+1, ptr+2, ... (mod N) and returns the first set request.
// The index arithmetic wraps naturally at IW bits, so N must be a power of two.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    // Walk candidates from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        logic [IW-1:0] cand;
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        cand   = '0;
        for (int i = N; i >= 1; i--) begin
            cand = ptr + IW'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            onehot = N'(1) << idx;
        end
    end

endmodule : rr_pick

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with bounded grant hold time.
// gnt is registered and always one-hot or zero; one idle bubble separates grants.
// Optional grant counter (gnt_cnt port) is built when RR_GNT_CNT_EN is defined.
module rr_arb4
    import arb_pkg::*;
#(
    parameter int N        = RR_N,
    parameter int MAX_HOLD = RR_MAX_HOLD,
    parameter int CNT_W    = RR_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             busy
`ifdef RR_GNT_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt
`endif
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    // The downstream 4:2 encoder fixes N; the hold limit needs at least two cycles.
    if (N != 4 || MAX_HOLD < 2 || CNT_W < 1) begin : g_bad_param
        $error("rr_arb4: illegal parameter set");
    end

    arb_state_e      state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic [N-1:0]    pick_onehot;
    logic            release_now;

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

`ifdef RR_GNT_CNT_EN
    logic [CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;
`endif

    // Next-state and register inputs; the release path hands priority past the old owner.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        hold_d      = hold_q;
        release_now = 1'b0;
`ifdef RR_GNT_CNT_EN
        gnt_cnt_d   = gnt_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    gnt_d   = pick_onehot;
                    owner_d = pick_idx;
                    hold_d  = '0;
`ifdef RR_GNT_CNT_EN
                    if (gnt_cnt_q != '1) begin
                        gnt_cnt_d = gnt_cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            GRANT: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HW'(1);
                end
                // Hold limit only forces a release when someone else is actually waiting.
                release_now = !req[owner_q] ||
                              ((hold_q == HOLD_LAST) && ((req & ~gnt_q) != '0));
                if (release_now) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; reset overrides any grant in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= IW'(N - 1);
            owner_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

`ifdef RR_GNT_CNT_EN
    // Saturating count of IDLE->GRANT transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt_q <= '0;
        end else begin
            gnt_cnt_q <= gnt_cnt_d;
        end
    end

    assign gnt_cnt = gnt_cnt_q;
`endif

    assign gnt  = gnt_q;
    assign busy = (state_q == GRANT);

endmodule : rr_arb4

// File: tb/tb_rr_arb4.sv
module tb_rr_arb4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        busy;
`ifdef RR_GNT_CNT_EN
    logic [15:0] gnt_cnt;
`endif

    int errors = 0;
    int checks = 0;

    rr_arb4 dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt),
        .busy (busy)
`ifdef RR_GNT_CNT_EN
        ,
        .gnt_cnt (gnt_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every-cycle invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (!$isunknown(gnt)) begin
            checks++;
            assert ($onehot0(gnt)) else begin
                errors++;
                $error("FAIL onehot0: observed=%b expected=onehot-or-zero", gnt);
            end
            checks++;
            assert (busy === (gnt != 4'b0000)) else begin
                errors++;
                $error("FAIL busy_vs_gnt: observed busy=%b expected=%b", busy, (gnt != 4'b0000));
            end
        end
    end

    logic [3:0] rot_seq [5];
    logic [3:0] exp_g;

    initial begin
        rot_seq[0] = 4'b0001;
        rot_seq[1] = 4'b0010;
        rot_seq[2] = 4'b0100;
        rot_seq[3] = 4'b1000;
        rot_seq[4] = 4'b0001;

        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);

        // T1: reset holds everything off, first grant goes to req[0]
        req = 4'b1111;
        tick();
        check("t1_rst_gnt", 32'(gnt), 32'h0);
        check("t1_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        check("t1_first_gnt", 32'(gnt), 32'b0001);

        // T2: rotation with each owner dropping after two cycles of grant
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t2_gnt%0d_c1", k), 32'(gnt), 32'(rot_seq[k]));
            tick();
            check($sformatf("t2_gnt%0d_c2", k), 32'(gnt), 32'(rot_seq[k]));
            req = 4'b1111 & ~rot_seq[k];
            tick();
            check($sformatf("t2_bubble%0d", k), 32'(gnt), 32'h0);
            req = 4'b1111;
            tick();
        end
        check("t2_after_wrap", 32'(gnt), 32'b0010);

        // T3: hold limit with two contenders
        rst = 1'b1;
        req = 4'b0011;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_own0_c%0d", i), 32'(gnt), 32'b0001);
            tick();
        end
        check("t3_bubble0", 32'(gnt), 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t3_own1_c%0d", i), 32'(gnt), 32'b0010);
            tick();
        end
        check("t3_bubble1", 32'(gnt), 32'h0);
        tick();
        check("t3_back_to0", 32'(gnt), 32'b0001);

        // T4: sole requester keeps the grant past the hold limit
        rst = 1'b1;
        req = 4'b0100;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t4_sole_c%0d", i), 32'(gnt), 32'b0100);
            tick();
        end

        // T5: reset in the middle of a grant
        rst = 1'b1;
        req = 4'b0010;
        tick();
        rst = 1'b0;
        tick();
        check("t5_owned", 32'(gnt), 32'b0010);
        tick();
        check("t5_still_owned", 32'(gnt), 32'b0010);
        rst = 1'b1;
        req = 4'b1111;
        tick();
        check("t5_rst_gnt", 32'(gnt), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        check("t5_after_rst", 32'(gnt), 32'b0001);

`ifdef RR_GNT_CNT_EN
        // T6: grant counter over eight rotated grants, cleared by reset
        rst = 1'b1;
        req = 4'b1111;
        tick();
        check("t6_cnt_rst", 32'(gnt_cnt), 32'h0);
        rst = 1'b0;
        for (int g = 1; g <= 8; g++) begin
            exp_g = 4'b0001 << ((g - 1) % 4);
            tick();
            check($sformatf("t6_gnt%0d", g), 32'(gnt), 32'(exp_g));
            check($sformatf("t6_cnt%0d", g), 32'(gnt_cnt), 32'(g));
            tick();
            req = 4'b1111 & ~exp_g;
            tick();
            req = 4'b1111;
        end
        check("t6_cnt_final", 32'(gnt_cnt), 32'd8);
        rst = 1'b1;
        tick();
        check("t6_cnt_cleared", 32'(gnt_cnt), 32'h0);
        rst = 1'b0;
`endif

        req = 4'b0000;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_rr_arb4
